// File: rtl/prog_loader.sv
// prog_loader: assembles a byte stream into 9-bit words for the instruction store.
// Define PROG_LOADER_CKSUM_EN to append an XOR checksum byte (CK state, Err output).
module prog_loader #(
    parameter int AW    = 6,
    parameter int IW    = 9,
    parameter int DEPTH = 64
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          InValid,
    input  logic [7:0]    InData,
    output logic          InReady,
    output logic          ImWen,
    output logic [AW-1:0] ImAddr,
    output logic [IW-1:0] ImDat,
    output logic          CpuHold,
    output logic          Busy,
    output logic          Done,
    output logic          Err
);
    typedef enum logic [2:0] {IDLE, HDR, LO, HI, WR, CK, DONE, ERR} state_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    state_t      state;
    logic [AW:0] rem;
    logic [7:0]  lo_q;
    logic        acc;

    assign acc = InValid & InReady;

`ifdef PROG_LOADER_CKSUM_EN
    logic [7:0] csum;
    logic       err_q;
    assign Err = err_q;
`else
    assign Err = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            InReady <= 1'b0;
            ImWen   <= 1'b0;
            ImAddr  <= '0;
            ImDat   <= '0;
            CpuHold <= 1'b1;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            rem     <= '0;
            lo_q    <= '0;
`ifdef PROG_LOADER_CKSUM_EN
            csum    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            ImWen <= 1'b0;
            unique case (state)
                IDLE, DONE, ERR: begin
                    if (Start) begin
                        state   <= HDR;
                        InReady <= 1'b1;
                        Busy    <= 1'b1;
                        Done    <= 1'b0;
                        CpuHold <= 1'b1;
`ifdef PROG_LOADER_CKSUM_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
                HDR: begin
                    if (acc) begin
                        state  <= LO;
                        ImAddr <= '0;
                        // a zero count field means a full store
                        rem    <= (InData[AW-1:0] == '0) ? FULL
                                                         : {1'b0, InData[AW-1:0]};
`ifdef PROG_LOADER_CKSUM_EN
                        csum   <= InData;
`endif
                    end
                end
                LO: begin
                    if (acc) begin
                        state <= HI;
                        lo_q  <= InData;
`ifdef PROG_LOADER_CKSUM_EN
                        csum  <= csum ^ InData;
`endif
                    end
                end
                HI: begin
                    if (acc) begin
                        state   <= WR;
                        InReady <= 1'b0;
                        ImWen   <= 1'b1;
                        ImDat   <= IW'({InData[0], lo_q});
`ifdef PROG_LOADER_CKSUM_EN
                        csum    <= csum ^ InData;
`endif
                    end
                end
                WR: begin
                    ImAddr <= ImAddr + AW'(1);
                    rem    <= rem - ONE;
                    if (rem != ONE) begin
                        state   <= LO;
                        InReady <= 1'b1;
                    end else begin
`ifdef PROG_LOADER_CKSUM_EN
                        state   <= CK;
                        InReady <= 1'b1;
`else
                        state   <= DONE;
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                        CpuHold <= 1'b0;
`endif
                    end
                end
`ifdef PROG_LOADER_CKSUM_EN
                CK: begin
                    if (acc) begin
                        InReady <= 1'b0;
                        Busy    <= 1'b0;
                        if (InData == csum) begin
                            state   <= DONE;
                            Done    <= 1'b1;
                            CpuHold <= 1'b0;
                        end else begin
                            state <= ERR;
                            err_q <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state   <= IDLE;
                    InReady <= 1'b0;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized loads checked by a write scoreboard and a stream-level model.
// Works with or without PROG_LOADER_CKSUM_EN defined.
module tb_prog_loader;
    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Start = 1'b0;
    logic       InValid = 1'b0;
    logic [7:0] InData = 8'h00;
    logic       InReady, ImWen, CpuHold, Busy, Done, Err;
    logic [5:0] ImAddr;
    logic [8:0] ImDat;

    prog_loader dut (
        .Clk(Clk), .Reset(Reset), .Start(Start),
        .InValid(InValid), .InData(InData), .InReady(InReady),
        .ImWen(ImWen), .ImAddr(ImAddr), .ImDat(ImDat),
        .CpuHold(CpuHold), .Busy(Busy), .Done(Done), .Err(Err)
    );

    always #5 Clk = ~Clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int cyc_start = 0;
    logic [14:0] exp_q[$];
    logic [7:0]  data_q[$];

`ifdef PROG_LOADER_CKSUM_EN
    localparam bit CKSUM = 1'b1;
`else
    localparam bit CKSUM = 1'b0;
`endif

    always @(posedge Clk) cyc++;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard monitor: every write pulse must match the next expected word
    always @(negedge Clk) begin
        if (Reset && ImWen) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {17'd0, ImAddr, ImDat}, 32'hFFFF_FFFF);
            end else begin
                logic [14:0] e;
                e = exp_q.pop_front();
                check("write_addr", {26'd0, ImAddr}, {26'd0, e[14:9]});
                check("write_data", {23'd0, ImDat}, {23'd0, e[8:0]});
                check("ready_in_wr", {31'd0, InReady}, 32'd0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int waited = 0;
        if (gaps) begin
            int g = $urandom_range(0, 2);
            if (g > 0) begin
                InValid = 1'b0;
                InData  = 8'($urandom);
                repeat (g) begin @(posedge Clk); #1; end
            end
        end
        InValid = 1'b1;
        InData  = b;
        while (!InReady && waited < 20) begin
            @(posedge Clk); #1;
            waited++;
        end
        if (!InReady) check("byte_timeout", 32'd0, 32'd1);
        @(posedge Clk); #1;
    endtask

    task automatic do_start();
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        cyc_start = cyc;
        check("start_busy", {31'd0, Busy}, 32'd1);
        check("start_hold", {31'd0, CpuHold}, 32'd1);
        check("start_done_clr", {31'd0, Done}, 32'd0);
        check("start_err_clr", {31'd0, Err}, 32'd0);
        check("start_ready", {31'd0, InReady}, 32'd1);
    endtask

    // one complete load; the model derives count, words and checksum from the stream
    task automatic do_load(input logic [7:0] hdr, input bit gaps,
                           input bit start_in_lo, input bit bad_ck);
        int n;
        logic [7:0] ck;
        int waited = 0;
        n = (hdr % 64 == 0) ? 64 : hdr % 64;
        if (data_q.size() == 0)
            for (int i = 0; i < 2 * n; i++) data_q.push_back(8'($urandom));
        ck = hdr;
        foreach (data_q[i]) ck ^= data_q[i];
        for (int i = 0; i < n; i++)
            exp_q.push_back({6'(i), data_q[2*i+1][0], data_q[2*i]});
        do_start();
        send_byte(hdr, gaps);
        if (start_in_lo) begin
            InValid = 1'b0;
            Start = 1'b1;
            @(posedge Clk); #1;
            Start = 1'b0;
            check("start_ignored_busy", {31'd0, Busy}, 32'd1);
        end
        for (int i = 0; i < n; i++) begin
            send_byte(data_q[2*i], gaps);
            send_byte(data_q[2*i+1], gaps);
            check("ready_low_wr", {31'd0, InReady}, 32'd0);
        end
        if (CKSUM) send_byte(bad_ck ? ((ck == 8'h00) ? 8'h01 : 8'h00) : ck, gaps);
        InValid = 1'b0;
        while (!Done && !Err && waited < 10) begin
            @(posedge Clk); #1;
            waited++;
        end
        if (!gaps && !start_in_lo)
            check("cycles_to_done", cyc - cyc_start, 3 * n + 1 + int'(CKSUM));
        check("writes_left", exp_q.size(), 0);
        check("final_addr", {26'd0, ImAddr}, n % 64);
        check("busy_end", {31'd0, Busy}, 32'd0);
        check("ready_end", {31'd0, InReady}, 32'd0);
        if (CKSUM && bad_ck) begin
            check("err_bad", {31'd0, Err}, 32'd1);
            check("done_bad", {31'd0, Done}, 32'd0);
            check("hold_bad", {31'd0, CpuHold}, 32'd1);
        end else begin
            check("done_ok", {31'd0, Done}, 32'd1);
            check("err_ok", {31'd0, Err}, 32'd0);
            check("hold_ok", {31'd0, CpuHold}, 32'd0);
        end
        exp_q.delete();
        data_q.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, {31'd0, InReady}, 32'd0);
        check({tag, "_wen"}, {31'd0, ImWen}, 32'd0);
        check({tag, "_addr"}, {26'd0, ImAddr}, 32'd0);
        check({tag, "_dat"}, {23'd0, ImDat}, 32'd0);
        check({tag, "_hold"}, {31'd0, CpuHold}, 32'd1);
        check({tag, "_busy"}, {31'd0, Busy}, 32'd0);
        check({tag, "_done"}, {31'd0, Done}, 32'd0);
        check({tag, "_err"}, {31'd0, Err}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        check_reset_vals("reset");
        Reset = 1'b1;
        @(posedge Clk); #1;

        data_q = '{8'h15, 8'h01, 8'hA3, 8'h00};
        do_load(8'h02, 1'b0, 1'b0, 1'b0);

        for (int t = 0; t < 6; t++)
            do_load(8'($urandom_range(1, 8) + 64 * $urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'b0, 1'b0);

        do_load(8'h00, 1'b1, 1'b0, 1'b0);
        do_load(8'h40, 1'b0, 1'b0, 1'b0);
        do_load(8'h03, 1'b0, 1'b1, 1'b0);

        if (CKSUM) begin
            data_q = '{8'h15, 8'h01, 8'hA3, 8'h00};
            do_load(8'h02, 1'b0, 1'b0, 1'b1);
            do_load(8'h04, 1'b1, 1'b0, 1'b0);
        end

        // abort after three words, in the middle of the fourth
        for (int i = 0; i < 6; i++) data_q.push_back(8'($urandom));
        for (int i = 0; i < 3; i++)
            exp_q.push_back({6'(i), data_q[2*i+1][0], data_q[2*i]});
        do_start();
        send_byte(8'h05, 1'b0);
        foreach (data_q[i]) send_byte(data_q[i], 1'b0);
        send_byte(8'($urandom), 1'b0);
        Reset = 1'b0;
        #1;
        check_reset_vals("abort");
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b1;
        repeat (4) @(posedge Clk);
        #1;
        InValid = 1'b0;
        check("abort_writes", exp_q.size(), 0);
        check("abort_idle_busy", {31'd0, Busy}, 32'd0);
        check("abort_idle_hold", {31'd0, CpuHold}, 32'd1);
        exp_q.delete();
        data_q.delete();

        do_load(8'h02, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
